// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// The MEM stage and the display scan-out reader use the same width constants.
// The read-return tag type is also defined here.
package dmem_arb_pkg;

    localparam int DMEM_DATA_W = 18;   // data word width (register file / ResultW)
    localparam int DMEM_ADDR_W = 10;   // data memory word-address width

    // Owner of the read data returning from the RAM in the current cycle.
    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_CPU  = 2'd1,
        R_VID  = 2'd2
    } rtag_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle around the data-memory arbiter.
//   cpu_*  : CPU MEM-stage request / stall / read data
//   vid_*  : display scan-out read request / grant / read return
//   mem_*  : single-port synchronous data RAM
// Modports:
//   slave  - the arbiter. It serves the requesters and drives the RAM port.
//   master - the surroundings. These are the requesters plus the RAM.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating wait counter that bounds how long the display can starve.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset, clears the count
//   inc    in  count one more lost cycle (saturates at MAX_WAIT)
//   clr    in  restart from zero (takes priority over inc)
//   at_max out count has reached MAX_WAIT
module arb_wait_counter #(
    parameter int MAX_WAIT = 4,
    localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        countNext = count;
        if (clr) begin
            countNext = '0;
        end else if (inc && (count != MAX_CNT)) begin
            countNext = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

    assign at_max = (count == MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter for the single-port synchronous data RAM.
// The CPU MEM stage has priority; a CPU read stalls the pipeline for one cycle.
// The display scan-out reader gets the port when the CPU is idle or waiting on a read return.
// The display also gets the port after MAX_WAIT consecutive lost cycles.
// Read data comes back one cycle after issue and is steered to its owner by rtagReg.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-low reset; all bus outputs are held at 0 while low
//   bus  slave view of dmem_port_arbiter_if (CPU, display and RAM sides)
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);

    rtag_t             rtagReg;
    rtag_t             rtagNext;
    logic [DATA_W-1:0] cpuRdataReg;

    logic cpuOk;
    logic vidWins;
    logic cpuGnt;
    logic vidGnt;
    logic cpuStall;
    logic vidAtMax;

    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] cpuRdata;
    logic [DATA_W-1:0] vidRdata;

    // Grants are suppressed while reset is asserted.
    // This keeps the counter and rtag consistent with the zeroed outputs.
    always_comb begin
        cpuOk    = 1'b0;
        vidWins  = 1'b0;
        cpuGnt   = 1'b0;
        vidGnt   = 1'b0;
        cpuStall = 1'b0;
        memEn    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        rtagNext = R_NONE;

        if (rst) begin
            // A CPU read in its return cycle must not reissue.
            // The display may use that cycle instead.
            cpuOk   = bus.cpu_req && (rtagReg != R_CPU);
            vidWins = bus.vid_req && (!cpuOk || vidAtMax);
            cpuGnt  = cpuOk && !vidWins;
            vidGnt  = vidWins;

            cpuStall = bus.cpu_req && !(cpuGnt && bus.cpu_we) && (rtagReg != R_CPU);

            memEn = cpuGnt || vidGnt;
            memWe = cpuGnt && bus.cpu_we;
            if (vidGnt) begin
                memAddr = bus.vid_addr;
            end else if (cpuGnt) begin
                memAddr  = bus.cpu_addr;
                memWdata = bus.cpu_wdata;
            end

            if (cpuGnt && !bus.cpu_we) begin
                rtagNext = R_CPU;
            end else if (vidGnt) begin
                rtagNext = R_VID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rtagReg <= R_NONE;
        end else begin
            rtagReg <= rtagNext;
        end
    end

    // Keep the last CPU read word visible after the return cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpuRdataReg <= '0;
        end else if (rtagReg == R_CPU) begin
            cpuRdataReg <= bus.mem_rdata;
        end
    end

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) waitCounter (
        .clk    (clk),
        .rst    (rst),
        .inc    (bus.vid_req && !vidGnt),
        .clr    (vidGnt || !bus.vid_req),
        .at_max (vidAtMax)
    );

    always_comb begin
        cpuRdata = cpuRdataReg;
        vidRdata = '0;
        if (rtagReg == R_CPU) begin
            cpuRdata = bus.mem_rdata;
        end
        if (rtagReg == R_VID) begin
            vidRdata = bus.mem_rdata;
        end
    end

    assign bus.cpu_stall  = cpuStall;
    assign bus.cpu_rdata  = rst ? cpuRdata : '0;
    assign bus.vid_gnt    = vidGnt;
    assign bus.vid_rvalid = rst && (rtagReg == R_VID);
    assign bus.vid_rdata  = rst ? vidRdata : '0;
    assign bus.mem_en     = memEn;
    assign bus.mem_we     = memWe;
    assign bus.mem_addr   = memAddr;
    assign bus.mem_wdata  = memWdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_port_arbiter;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(
        .DATA_W   (18),
        .ADDR_W   (10),
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM: a write updates the array and a read returns data next cycle.
    logic [17:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
    endtask

    task automatic cpuDrive(input logic we, input logic [9:0] addr, input logic [17:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    // Single-cycle CPU write with no display contention.
    task automatic cpuWrite(input logic [9:0] addr, input logic [17:0] wdata);
        idle();
        cpuDrive(1'b1, addr, wdata);
        #1;
        $display("txn cpu write addr=0x%03h data=0x%05h", addr, wdata);
        check("wr_stall", bus.cpu_stall, 1'b0);
        check("wr_mem_en", bus.mem_en, 1'b1);
        tick();
        idle();
    endtask

    initial begin
        idle();
        bus.mem_rdata = '0;
        rst = 1'b0;

        // Hold reset with both requesters asserted; nothing may be granted.
        bus.cpu_req  = 1'b1;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h005;
        tick();
        tick();
        $display("txn reset hold with requests");
        check("rst_stall", bus.cpu_stall, 1'b0);
        check("rst_vid_gnt", bus.vid_gnt, 1'b0);
        check("rst_mem_en", bus.mem_en, 1'b0);
        check("rst_cpu_rdata", bus.cpu_rdata, 18'h0);
        idle();
        rst = 1'b1;
        #1;
        check("post_rst_rvalid", bus.vid_rvalid, 1'b0);

        // Test 2: CPU write, granted in the same cycle.
        idle();
        cpuDrive(1'b1, 10'h005, 18'h3FFFF);
        #1;
        $display("txn cpu write addr=0x005 data=0x3ffff");
        check("t2_mem_en", bus.mem_en, 1'b1);
        check("t2_mem_we", bus.mem_we, 1'b1);
        check("t2_mem_addr", bus.mem_addr, 10'h005);
        check("t2_mem_wdata", bus.mem_wdata, 18'h3FFFF);
        check("t2_stall", bus.cpu_stall, 1'b0);
        tick();
        idle();

        // Preload data used by the read tests.
        cpuWrite(10'h010, 18'h12345);
        cpuWrite(10'h020, 18'h00777);
        cpuWrite(10'h030, 18'h2AAAA);

        // Test 3: CPU read with a single stall cycle.
        cpuDrive(1'b0, 10'h010, 18'h0);
        #1;
        $display("txn cpu read addr=0x010 issue");
        check("t3_c0_stall", bus.cpu_stall, 1'b1);
        check("t3_c0_mem_en", bus.mem_en, 1'b1);
        check("t3_c0_mem_we", bus.mem_we, 1'b0);
        check("t3_c0_mem_addr", bus.mem_addr, 10'h010);
        tick();
        $display("txn cpu read addr=0x010 return");
        check("t3_c1_stall", bus.cpu_stall, 1'b0);
        check("t3_c1_rdata", bus.cpu_rdata, 18'h12345);
        check("t3_c1_no_reissue", bus.mem_en, 1'b0);
        idle();
        tick();
        check("t3_rdata_hold", bus.cpu_rdata, 18'h12345);

        // Test 4: CPU write stream with the display waiting; the display wins on the 5th cycle.
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h020;
        for (int k = 0; k < 4; k++) begin
            cpuDrive(1'b1, 10'h100 + 10'(k), 18'h00100 + 18'(k));
            #1;
            $display("txn cpu write addr=0x%03h while display waits (lost %0d)", 10'h100 + 10'(k), k + 1);
            check($sformatf("t4_lose%0d_vid_gnt", k), bus.vid_gnt, 1'b0);
            check($sformatf("t4_lose%0d_stall", k), bus.cpu_stall, 1'b0);
            tick();
        end
        cpuDrive(1'b1, 10'h104, 18'h00104);
        #1;
        $display("txn display read addr=0x020 forced after max wait");
        check("t4_vid_gnt", bus.vid_gnt, 1'b1);
        check("t4_stall", bus.cpu_stall, 1'b1);
        check("t4_mem_addr", bus.mem_addr, 10'h020);
        check("t4_mem_we", bus.mem_we, 1'b0);
        check("t4_mem_wdata", bus.mem_wdata, 18'h0);
        tick();
        bus.vid_req = 1'b0;
        #1;
        check("t4_vid_rvalid", bus.vid_rvalid, 1'b1);
        check("t4_vid_rdata", bus.vid_rdata, 18'h00777);
        check("t4_wait_cleared", 32'(dut.waitCounter.count), 32'd0);
        check("t4_cpu_write_now", bus.cpu_stall, 1'b0);
        tick();
        idle();

        // Test 5: a pending display read uses the CPU read-return cycle.
        cpuDrive(1'b0, 10'h030, 18'h0);
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h010;
        #1;
        $display("txn cpu read addr=0x030 with display pending");
        check("t5_c0_stall", bus.cpu_stall, 1'b1);
        check("t5_c0_vid_gnt", bus.vid_gnt, 1'b0);
        tick();
        $display("txn display read addr=0x010 in cpu return cycle");
        check("t5_c1_vid_gnt", bus.vid_gnt, 1'b1);
        check("t5_c1_stall", bus.cpu_stall, 1'b0);
        check("t5_c1_cpu_rdata", bus.cpu_rdata, 18'h2AAAA);
        check("t5_c1_mem_addr", bus.mem_addr, 10'h010);
        tick();
        idle();
        #1;
        check("t5_c2_vid_rvalid", bus.vid_rvalid, 1'b1);
        check("t5_c2_vid_rdata", bus.vid_rdata, 18'h12345);
        check("t5_c2_cpu_hold", bus.cpu_rdata, 18'h2AAAA);
        tick();
        check("t5_c3_vid_rvalid", bus.vid_rvalid, 1'b0);
        check("t5_c3_vid_rdata", bus.vid_rdata, 18'h0);

        // Test 6: write then read the same address returns the new data.
        cpuWrite(10'h00A, 18'h0ABCD);
        cpuDrive(1'b0, 10'h00A, 18'h0);
        #1;
        $display("txn cpu read addr=0x00a after write");
        check("t6_c0_stall", bus.cpu_stall, 1'b1);
        tick();
        check("t6_c1_rdata", bus.cpu_rdata, 18'h0ABCD);
        check("t6_c1_stall", bus.cpu_stall, 1'b0);
        idle();
        tick();
        check("t6_rdata_hold", bus.cpu_rdata, 18'h0ABCD);

        // Test 1: reset lands on a display read-return cycle.
        bus.vid_req  = 1'b1;
        bus.vid_addr = 10'h005;
        #1;
        $display("txn display read addr=0x005 then reset");
        check("t1_vid_gnt", bus.vid_gnt, 1'b1);
        tick();
        rst = 1'b0;
        #1;
        check("t1_vid_rvalid", bus.vid_rvalid, 1'b0);
        check("t1_vid_rdata", bus.vid_rdata, 18'h0);
        check("t1_vid_gnt_rst", bus.vid_gnt, 1'b0);
        check("t1_mem_en", bus.mem_en, 1'b0);
        check("t1_cpu_rdata", bus.cpu_rdata, 18'h0);
        idle();
        tick();
        rst = 1'b1;
        #1;
        check("t1_no_late_rvalid", bus.vid_rvalid, 1'b0);
        tick();
        check("t1_still_quiet", bus.vid_rvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
